// File: rtl/sha3_axil_pkg.sv
// Shared definitions for the SHA3 AXI4-Lite sequencer: register map, bit fields,
// response codes and the sequencer state encoding.
package sha3_axil_pkg;

  localparam logic [3:0] ADDR_DATA   = 4'h0;
  localparam logic [3:0] ADDR_CTRL   = 4'h4;
  localparam logic [3:0] ADDR_STATUS = 4'h8;
  localparam logic [3:0] ADDR_DIGEST = 4'hC;

  localparam int CTRL_START_BIT  = 0;
  localparam int CTRL_BYTES_LSB  = 1;
  localparam int STATUS_DONE_BIT = 0;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_DATA,
    S_WR_CTRL,
    S_POLL,
    S_RD_DIG,
    S_DIG_OUT
  } seq_state_e;

endpackage

// File: rtl/axil_single_xfer.sv
// One-shot AXI4-Lite master engine: a start pulse while idle launches exactly one
// read or write; done_o marks the response handshake cycle with its resp/rdata.
module axil_single_xfer #(
  parameter int DW = 32,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  input  logic          is_write_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic          idle_o,
  output logic          done_o,
  output logic [DW-1:0] rdata_o,
  output logic [1:0]    resp_o,
  output logic [AW-1:0] awaddr_o,
  output logic          awvalid_o,
  input  logic          awready_i,
  output logic [DW-1:0] wdata_o,
  output logic          wvalid_o,
  input  logic          wready_i,
  input  logic [1:0]    bresp_i,
  input  logic          bvalid_i,
  output logic          bready_o,
  output logic [AW-1:0] araddr_o,
  output logic          arvalid_o,
  input  logic          arready_i,
  input  logic [DW-1:0] rdata_i,
  input  logic [1:0]    rresp_i,
  input  logic          rvalid_i,
  output logic          rready_o
);

  logic          awvalid_q, awvalid_d;
  logic          wvalid_q, wvalid_d;
  logic          bready_q, bready_d;
  logic          arvalid_q, arvalid_d;
  logic          rready_q, rready_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;

  assign idle_o = !(awvalid_q || wvalid_q || bready_q || arvalid_q || rready_q);

  always_comb begin
    // NOTE: every _d is given its hold value first so no branch can infer a latch.
    awvalid_d = awvalid_q && !awready_i;
    wvalid_d  = wvalid_q && !wready_i;
    arvalid_d = arvalid_q && !arready_i;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    // B is accepted only once both AW and W have been taken by the slave.
    bready_d  = bready_q ? !bvalid_i
                         : ((awvalid_q || wvalid_q) && !awvalid_d && !wvalid_d);
    rready_d  = rready_q ? !rvalid_i : (arvalid_q && arready_i);
    if (start_i && idle_o) begin
      addr_d  = addr_i;
      wdata_d = wdata_i;
      if (is_write_i) begin
        awvalid_d = 1'b1;
        wvalid_d  = 1'b1;
      end else begin
        arvalid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register updates together on the edge.
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign done_o    = (bready_q && bvalid_i) || (rready_q && rvalid_i);
  assign resp_o    = bready_q ? bresp_i : rresp_i;
  assign rdata_o   = rdata_i;
  assign awaddr_o  = addr_q;
  assign araddr_o  = addr_q;
  assign wdata_o   = wdata_q;
  assign awvalid_o = awvalid_q;
  assign wvalid_o  = wvalid_q;
  assign bready_o  = bready_q;
  assign arvalid_o = arvalid_q;
  assign rready_o  = rready_q;

endmodule

// File: rtl/sha3_axil_sequencer.sv
// Autonomous AXI4-Lite sequencer for the SHA3 core: writes message words and the
// final CTRL word, polls STATUS, then streams the DIGEST words out.
module sha3_axil_sequencer
  import sha3_axil_pkg::*;
#(
  parameter int DW           = 32,
  parameter int AW           = 4,
  parameter int DIGEST_WORDS = 16,
  parameter int POLL_LIMIT   = 1024
) (
  input  logic          s00_axi_aclk,
  input  logic          s00_axi_aresetn,
  input  logic          msg_valid,
  output logic          msg_ready,
  input  logic [DW-1:0] msg_data,
  input  logic          msg_last,
  input  logic [1:0]    msg_bytes,
  output logic          dig_valid,
  input  logic          dig_ready,
  output logic [DW-1:0] dig_data,
  output logic          dig_last,
  output logic          busy,
  output logic          err,
  output logic [AW-1:0] m00_axi_awaddr,
  output logic [2:0]    m00_axi_awprot,
  output logic          m00_axi_awvalid,
  input  logic          m00_axi_awready,
  output logic [DW-1:0] m00_axi_wdata,
  output logic [DW/8-1:0] m00_axi_wstrb,
  output logic          m00_axi_wvalid,
  input  logic          m00_axi_wready,
  input  logic [1:0]    m00_axi_bresp,
  input  logic          m00_axi_bvalid,
  output logic          m00_axi_bready,
  output logic [AW-1:0] m00_axi_araddr,
  output logic [2:0]    m00_axi_arprot,
  output logic          m00_axi_arvalid,
  input  logic          m00_axi_arready,
  input  logic [DW-1:0] m00_axi_rdata,
  input  logic [1:0]    m00_axi_rresp,
  input  logic          m00_axi_rvalid,
  output logic          m00_axi_rready
);

  localparam int DCW = $clog2(DIGEST_WORDS);
  localparam int PCW = $clog2(POLL_LIMIT + 1);
  localparam logic [DCW-1:0] DIG_LAST_IDX = DCW'(DIGEST_WORDS - 1);
  localparam logic [PCW-1:0] POLL_MAX     = PCW'(POLL_LIMIT);

  seq_state_e     state_q, state_d;
  logic [DW-1:0]  data_q, data_d, dig_q, dig_d;
  logic           last_q, last_d, drop_q, drop_d, busy_q, busy_d, msg_ready_q;
  logic [1:0]     bytes_q, bytes_d;
  logic [DCW-1:0] dig_cnt_q, dig_cnt_d;
  logic [PCW-1:0] poll_cnt_q, poll_cnt_d;

  logic           xfer_start, xfer_write, xfer_idle, xfer_done, err_c;
  logic [AW-1:0]  xfer_addr;
  logic [DW-1:0]  xfer_wdata, xfer_rdata, ctrl_word;
  logic [1:0]     xfer_resp;

  assign dig_valid = (state_q == S_DIG_OUT);

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    last_d     = last_q;
    bytes_d    = bytes_q;
    drop_d     = drop_q;
    busy_d     = busy_q;
    dig_d      = dig_q;
    dig_cnt_d  = dig_cnt_q;
    poll_cnt_d = poll_cnt_q;
    err_c      = 1'b0;
    xfer_start = 1'b0;
    xfer_write = 1'b0;
    xfer_addr  = AW'(ADDR_DATA);
    xfer_wdata = data_q;
    ctrl_word  = '0;
    ctrl_word[CTRL_START_BIT]       = 1'b1;
    ctrl_word[CTRL_BYTES_LSB +: 2]  = bytes_q;

    unique case (state_q)
      S_IDLE: begin
        if (msg_valid && msg_ready_q) begin
          // After an error the rest of the message is swallowed up to msg_last.
          if (drop_q) begin
            drop_d = !msg_last;
          end else begin
            data_d  = msg_data;
            last_d  = msg_last;
            bytes_d = msg_bytes;
            busy_d  = 1'b1;
            state_d = S_WR_DATA;
          end
        end
      end
      S_WR_DATA, S_WR_CTRL: begin
        xfer_start = 1'b1;
        xfer_write = 1'b1;
        if (state_q == S_WR_CTRL) begin
          xfer_addr  = AW'(ADDR_CTRL);
          xfer_wdata = ctrl_word;
        end
        if (xfer_done) begin
          if (xfer_resp != RESP_OKAY) begin
            err_c   = 1'b1;
            busy_d  = 1'b0;
            drop_d  = (state_q == S_WR_DATA) && !last_q;
            state_d = S_IDLE;
          end else if (state_q == S_WR_CTRL) begin
            poll_cnt_d = '0;
            state_d    = S_POLL;
          end else begin
            state_d = last_q ? S_WR_CTRL : S_IDLE;
          end
        end
      end
      S_POLL: begin
        xfer_start = 1'b1;
        xfer_addr  = AW'(ADDR_STATUS);
        if (xfer_done) begin
          if (xfer_resp != RESP_OKAY || (!xfer_rdata[STATUS_DONE_BIT] &&
                                         poll_cnt_q == POLL_MAX - PCW'(1))) begin
            err_c   = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else if (xfer_rdata[STATUS_DONE_BIT]) begin
            dig_cnt_d = '0;
            state_d   = S_RD_DIG;
          end else if (poll_cnt_q != POLL_MAX) begin
            poll_cnt_d = poll_cnt_q + PCW'(1);
          end
        end
      end
      S_RD_DIG: begin
        xfer_start = 1'b1;
        xfer_addr  = AW'(ADDR_DIGEST);
        if (xfer_done) begin
          if (xfer_resp != RESP_OKAY) begin
            err_c   = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            dig_d   = xfer_rdata;
            state_d = S_DIG_OUT;
          end
        end
      end
      S_DIG_OUT: begin
        if (dig_ready) begin
          if (dig_cnt_q == DIG_LAST_IDX) begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            dig_cnt_d = dig_cnt_q + DCW'(1);
            state_d   = S_RD_DIG;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      state_q     <= S_IDLE;
      data_q      <= '0;
      last_q      <= 1'b0;
      bytes_q     <= '0;
      drop_q      <= 1'b0;
      busy_q      <= 1'b0;
      msg_ready_q <= 1'b0;
      dig_q       <= '0;
      dig_cnt_q   <= '0;
      poll_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      last_q      <= last_d;
      bytes_q     <= bytes_d;
      drop_q      <= drop_d;
      busy_q      <= busy_d;
      msg_ready_q <= (state_d == S_IDLE);
      dig_q       <= dig_d;
      dig_cnt_q   <= dig_cnt_d;
      poll_cnt_q  <= poll_cnt_d;
    end
  end

  axil_single_xfer #(.DW(DW), .AW(AW)) u_xfer (
    .clk        (s00_axi_aclk),
    .rst_n      (s00_axi_aresetn),
    .start_i    (xfer_start),
    .is_write_i (xfer_write),
    .addr_i     (xfer_addr),
    .wdata_i    (xfer_wdata),
    .idle_o     (xfer_idle),
    .done_o     (xfer_done),
    .rdata_o    (xfer_rdata),
    .resp_o     (xfer_resp),
    .awaddr_o   (m00_axi_awaddr),
    .awvalid_o  (m00_axi_awvalid),
    .awready_i  (m00_axi_awready),
    .wdata_o    (m00_axi_wdata),
    .wvalid_o   (m00_axi_wvalid),
    .wready_i   (m00_axi_wready),
    .bresp_i    (m00_axi_bresp),
    .bvalid_i   (m00_axi_bvalid),
    .bready_o   (m00_axi_bready),
    .araddr_o   (m00_axi_araddr),
    .arvalid_o  (m00_axi_arvalid),
    .arready_i  (m00_axi_arready),
    .rdata_i    (m00_axi_rdata),
    .rresp_i    (m00_axi_rresp),
    .rvalid_i   (m00_axi_rvalid),
    .rready_o   (m00_axi_rready)
  );

  assign msg_ready      = msg_ready_q;
  assign dig_data       = dig_q;
  assign dig_last       = dig_valid && (dig_cnt_q == DIG_LAST_IDX);
  assign busy           = busy_q;
  assign err            = err_c;
  assign m00_axi_awprot = 3'b000;
  assign m00_axi_arprot = 3'b000;
  assign m00_axi_wstrb  = {(DW/8){1'b1}};

endmodule

// File: tb/tb_sha3_axil_sequencer.sv
// Directed bench: a cycle-stepped AXI4-Lite slave model plus message source and
// digest sink drive the sequencer; expected traffic is hand-derived per scenario.
module tb_sha3_axil_sequencer;
  import sha3_axil_pkg::*;

  localparam int DW = 32, AW = 4, NDIG = 16, PLIM = 8;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic msg_valid = 0, msg_ready, msg_last = 0, dig_valid, dig_ready = 0, dig_last, busy, err;
  logic [31:0] msg_data = '0, dig_data, wdata, rdata = '0;
  logic [1:0] msg_bytes = '0, bresp = '0, rresp = '0;
  logic [3:0] awaddr, araddr, wstrb;
  logic [2:0] awprot, arprot;
  logic awvalid, awready = 0, wvalid, wready = 0, bvalid = 0, bready;
  logic arvalid, arready = 0, rvalid = 0, rready;

  sha3_axil_sequencer #(.DW(DW), .AW(AW), .DIGEST_WORDS(NDIG), .POLL_LIMIT(PLIM)) dut (
    .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n),
    .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_data(msg_data),
    .msg_last(msg_last), .msg_bytes(msg_bytes),
    .dig_valid(dig_valid), .dig_ready(dig_ready), .dig_data(dig_data), .dig_last(dig_last),
    .busy(busy), .err(err),
    .m00_axi_awaddr(awaddr), .m00_axi_awprot(awprot), .m00_axi_awvalid(awvalid),
    .m00_axi_awready(awready), .m00_axi_wdata(wdata), .m00_axi_wstrb(wstrb),
    .m00_axi_wvalid(wvalid), .m00_axi_wready(wready), .m00_axi_bresp(bresp),
    .m00_axi_bvalid(bvalid), .m00_axi_bready(bready), .m00_axi_araddr(araddr),
    .m00_axi_arprot(arprot), .m00_axi_arvalid(arvalid), .m00_axi_arready(arready),
    .m00_axi_rdata(rdata), .m00_axi_rresp(rresp), .m00_axi_rvalid(rvalid),
    .m00_axi_rready(rready)
  );

  typedef struct packed { logic [31:0] d; logic l; logic [1:0] b; } msg_t;
  msg_t        msgq[$];
  logic [31:0] rx_d[$], wl_d[$];
  logic        rx_l[$];
  logic [3:0]  wl_a[$];

  int n_cmp = 0, n_bad = 0;
  int aw_delay = 0, err_at = -1, done_after = 0;
  logic [31:0] dig_base = '0;
  logic sink_ready = 1'b1;
  int err_cnt, status_reads, ar_total, dig_idx, wr_idx, aw_hold, w_first, aw_unstable;
  int ar_while_dv = 0;
  bit busy_seen;

  bit aw_got, w_got, ar_got;
  int aw_cnt;
  logic [3:0] aw_a, ar_a;
  logic [31:0] w_d;

  logic s_awv, s_awr, s_wv, s_wr, s_bv, s_br, s_arv, s_arr, s_rv, s_rr;
  logic s_mv, s_mr, s_dv, s_dr, s_dl, s_err;
  logic [3:0] s_awa, s_ara;
  logic [31:0] s_wd, s_dd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Slave/source/sink model: retire handshakes from last snapshot, drive, then snapshot.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        aw_got = 0; w_got = 0; ar_got = 0; aw_cnt = 0;
        awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
        msg_valid = 0; dig_ready = 0;
      end else begin
        if (s_awv && s_awr) begin aw_got = 1; aw_a = s_awa; aw_cnt = 0; end
        if (s_wv && s_wr) begin w_got = 1; w_d = s_wd; end
        if (s_bv && s_br) begin
          wl_a.push_back(aw_a); wl_d.push_back(w_d);
          aw_got = 0; w_got = 0; bvalid = 0;
        end
        if (s_arv && s_arr) begin ar_got = 1; ar_a = s_ara; ar_total++; end
        if (s_rv && s_rr) begin ar_got = 0; rvalid = 0; end
        if (s_mv && s_mr && msgq.size() > 0) void'(msgq.pop_front());
        if (s_dv && s_dr) begin rx_d.push_back(s_dd); rx_l.push_back(s_dl); end
        if (s_err) err_cnt++;

        awready = 0;
        if (awvalid && !aw_got) begin
          if (aw_cnt >= aw_delay) awready = 1; else aw_cnt++;
        end
        wready = wvalid && !w_got;
        if (aw_got && w_got && !bvalid) begin
          bvalid = 1;
          bresp  = (wr_idx == err_at) ? 2'b10 : 2'b00;
          wr_idx++;
        end
        arready = arvalid && !ar_got;
        if (ar_got && !rvalid) begin
          rvalid = 1; rresp = 2'b00;
          if (ar_a == ADDR_STATUS) begin
            status_reads++;
            rdata = (status_reads > done_after) ? 32'h1 : 32'h0;
          end else begin
            rdata = dig_base + dig_idx;
            dig_idx++;
          end
        end
        if (msgq.size() > 0) begin
          msg_valid = 1; msg_data = msgq[0].d; msg_last = msgq[0].l; msg_bytes = msgq[0].b;
        end else begin
          msg_valid = 0;
        end
        dig_ready = sink_ready;
      end
      #1;
      if (awvalid && !awready) aw_hold++;
      if (awvalid && !wvalid) w_first++;
      if (s_awv && !s_awr && awvalid && awaddr !== s_awa) aw_unstable++;
      if (arvalid && dig_valid) ar_while_dv++;
      if (busy) busy_seen = 1;
      s_awv = awvalid; s_awr = awready; s_awa = awaddr; s_wv = wvalid; s_wr = wready; s_wd = wdata;
      s_bv = bvalid; s_br = bready; s_arv = arvalid; s_arr = arready; s_ara = araddr;
      s_rv = rvalid; s_rr = rready; s_mv = msg_valid; s_mr = msg_ready;
      s_dv = dig_valid; s_dr = dig_ready; s_dd = dig_data; s_dl = dig_last; s_err = err;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #3; end
  endtask

  task automatic clear_log();
    wl_a.delete(); wl_d.delete(); rx_d.delete(); rx_l.delete();
    err_cnt = 0; status_reads = 0; ar_total = 0; dig_idx = 0; wr_idx = 0;
    aw_hold = 0; w_first = 0; aw_unstable = 0; busy_seen = 0;
  endtask

  task automatic push(input logic [31:0] d, input logic l, input logic [1:0] b);
    msgq.push_back('{d: d, l: l, b: b});
  endtask

  task automatic wait_rx(input string tag, input int n);
    int k = 0;
    while (rx_d.size() < n && k < 4000) begin tick(1); k++; end
    check({tag, "_rx_count"}, rx_d.size(), n);
  endtask

  task automatic check_digest(input string tag, input logic [31:0] base);
    for (int i = 0; i < NDIG; i++) begin
      if (i < rx_d.size()) begin
        check($sformatf("%s_dig%0d", tag, i), rx_d[i], base + i);
        check($sformatf("%s_last%0d", tag, i), {31'b0, rx_l[i]}, (i == NDIG - 1) ? 1 : 0);
      end
    end
  endtask

  task automatic check_write(input string tag, input int i, input logic [3:0] a, input logic [31:0] d);
    if (i < wl_a.size()) begin
      check($sformatf("%s_wa%0d", tag, i), {28'b0, wl_a[i]}, {28'b0, a});
      check($sformatf("%s_wd%0d", tag, i), wl_d[i], d);
    end
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k, n0, unstable, ctrl_writes;
    logic [31:0] d0;
    clear_log();
    tick(3);
    check("rst_valids", {27'b0, awvalid, wvalid, arvalid, bready, rready}, 0);
    check("rst_msg_ready", {31'b0, msg_ready}, 0);
    check("rst_dig", {29'b0, dig_valid, dig_last, busy}, 0);
    check("rst_err", {31'b0, err}, 0);
    check("rst_dig_data", dig_data, 0);
    rst_n = 1'b1;
    tick(2);
    check("idle_msg_ready", {31'b0, msg_ready}, 1);

    // 1: three-word message, slave always ready
    clear_log(); dig_base = 32'hD000_0000; done_after = 0;
    push(32'h6162_6364, 0, 2'd3); push(32'h6566_6768, 0, 2'd3); push(32'h6162_6300, 1, 2'd2);
    wait_rx("t1", NDIG);
    check("t1_nwrites", wl_a.size(), 4);
    check_write("t1", 0, ADDR_DATA, 32'h6162_6364);
    check_write("t1", 1, ADDR_DATA, 32'h6566_6768);
    check_write("t1", 2, ADDR_DATA, 32'h6162_6300);
    check_write("t1", 3, ADDR_CTRL, 32'h5);
    check("t1_status_reads", status_reads, 1);
    check_digest("t1", 32'hD000_0000);
    check("t1_err", err_cnt, 0);
    check("t1_busy_after", {31'b0, busy}, 0);

    // 2: STATUS done on the sixth read
    clear_log(); dig_base = 32'hE000_0000; done_after = 5;
    push(32'h1234_5678, 1, 2'd3);
    wait_rx("t2", NDIG);
    check("t2_status_reads", status_reads, 6);
    check_write("t2", 1, ADDR_CTRL, 32'h7);
    check_digest("t2", 32'hE000_0000);
    check("t2_busy_seen", {31'b0, busy_seen}, 1);
    check("t2_busy_after", {31'b0, busy}, 0);

    // 3: awready delayed three cycles, wready immediate
    clear_log(); dig_base = 32'h1000_0000; done_after = 0; aw_delay = 3;
    push(32'hA5A5_0001, 1, 2'd3);
    wait_rx("t3", NDIG);
    aw_delay = 0;
    check("t3_nwrites", wl_a.size(), 2);
    check_write("t3", 0, ADDR_DATA, 32'hA5A5_0001);
    check_write("t3", 1, ADDR_CTRL, 32'h7);
    check("t3_aw_hold", aw_hold, 6);
    check("t3_w_first", {31'b0, w_first > 0}, 1);
    check("t3_aw_stable", aw_unstable, 0);

    // 4: SLVERR on second DATA write, then a clean message
    clear_log(); err_at = 1;
    push(32'h1111_1111, 0, 2'd3); push(32'h2222_2222, 0, 2'd3); push(32'h3333_3333, 1, 2'd3);
    k = 0;
    while ((err_cnt < 1 || msgq.size() != 0) && k < 1000) begin tick(1); k++; end
    tick(10);
    ctrl_writes = 0;
    foreach (wl_a[i]) if (wl_a[i] == ADDR_CTRL) ctrl_writes++;
    check("t4_err_cycles", err_cnt, 1);
    check("t4_nwrites", wl_a.size(), 2);
    check("t4_ctrl_writes", ctrl_writes, 0);
    check("t4_no_reads", ar_total, 0);
    check("t4_msg_drained", msgq.size(), 0);
    check("t4_busy", {31'b0, busy}, 0);
    err_at = -1;
    clear_log(); dig_base = 32'h4000_0000;
    push(32'hCAFE_BABE, 1, 2'd1);
    wait_rx("t4b", NDIG);
    check("t4b_nwrites", wl_a.size(), 2);
    check_write("t4b", 0, ADDR_DATA, 32'hCAFE_BABE);
    check_write("t4b", 1, ADDR_CTRL, 32'h3);
    check_digest("t4b", 32'h4000_0000);
    check("t4b_err", err_cnt, 0);

    // 5: digest sink stalls ten cycles mid-stream
    clear_log(); dig_base = 32'hF000_0000;
    push(32'h5555_AAAA, 1, 2'd3);
    wait_rx("t5a", 5);
    sink_ready = 1'b0;
    tick(1);
    k = 0;
    while (!dig_valid && k < 100) begin tick(1); k++; end
    n0 = rx_d.size(); d0 = dig_data; unstable = 0;
    repeat (10) begin
      tick(1);
      if (dig_data !== d0 || !dig_valid) unstable++;
    end
    check("t5_stall_rx", rx_d.size(), n0);
    check("t5_stall_data", d0, 32'hF000_0000 + n0);
    check("t5_stall_stable", unstable, 0);
    check("t5_no_ar_in_stall", ar_while_dv, 0);
    sink_ready = 1'b1;
    wait_rx("t5", NDIG);
    check_digest("t5", 32'hF000_0000);

    // 6: done never set -> timeout after PLIM reads
    clear_log(); done_after = 1000;
    push(32'h6666_6666, 1, 2'd3);
    k = 0;
    while (err_cnt < 1 && k < 1000) begin tick(1); k++; end
    tick(3);
    check("t6_status_reads", status_reads, PLIM);
    check("t6_err_cycles", err_cnt, 1);
    check("t6_no_digest", dig_idx, 0);
    check("t6_rx", rx_d.size(), 0);
    check("t6_idle", {30'b0, msg_ready, busy}, 2);

    // 6b: asynchronous reset in the middle of a held write
    clear_log(); done_after = 0; aw_delay = 20;
    push(32'h7777_0001, 0, 2'd3); push(32'h7777_0002, 1, 2'd3);
    k = 0;
    while (!awvalid && k < 100) begin tick(1); k++; end
    check("t6b_awvalid_up", {31'b0, awvalid}, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6b_rst_valids", {24'b0, awvalid, wvalid, arvalid, bready, rready,
                             dig_valid, msg_ready, busy}, 0);
    msgq.delete(); aw_delay = 0;
    tick(2);
    rst_n = 1'b1;
    tick(3);
    check("t6b_recovered", {31'b0, msg_ready}, 1);

    check("ar_while_dig_valid", ar_while_dv, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
